fifo_rd_stream: RTL and testbench

//  Read-side consumer for the dual-clock FIFO; lives entirely in the read clock domain.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_rd_skid.sv | 78 +++++++
 rtl/gnrl_dffr.sv | 16 +
 rtl/fifo_rd_stream.sv | 85 ++++++++
 tb/tb_fifo_rd_stream.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO read side: occupancy states,
// the read-latency legality macro and a width helper for buffer pointers.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_RD_LATENCY_LEGAL(lat) (((lat) >= 1) && ((lat) <= 2))

package fifo_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_PART  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  // Bits needed to encode values 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

`endif

// File: rtl/fifo_rd_skid.sv
// Circular register buffer of DEPTH entries with push/pop, an occupancy
// count and a three-state occupancy FSM that drives the valid flag.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned OCC_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_WIDTH-1:0]  occ
);

  localparam int unsigned          PW       = clog2_min1(DEPTH);
  localparam logic [PW-1:0]        LAST     = PW'(DEPTH - 1);
  localparam logic [OCC_WIDTH-1:0] FULL_OCC = OCC_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  occ_state_e            state;
  occ_state_e            state_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // A push into a full buffer only happens alongside a pop, so tail==head
  // then overwrites the slot being consumed this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      if (push && !pop)      occ <= occ + OCC_WIDTH'(1);
      else if (pop && !push) occ <= occ - OCC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OCC_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      OCC_EMPTY: if (push) state_nxt = OCC_PART;
      OCC_PART: begin
        if (push && !pop && (occ == FULL_OCC - OCC_WIDTH'(1)))
          state_nxt = OCC_FULL;
        else if (pop && !push && (occ == OCC_WIDTH'(1)))
          state_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (pop && !push) state_nxt = OCC_PART;
      default:   state_nxt = OCC_EMPTY;
    endcase
  end

  always_comb begin
    valid     = (state != OCC_EMPTY);
    head_data = mem[head];
  end

endmodule

// File: rtl/gnrl_dffr.sv
// Plain flop with asynchronous active-low reset to zero.
module gnrl_dffr #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qout <= '0;
    else        qout <= dnxt;
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the dual-clock FIFO: credit-based read issue, an
// in-flight pipe matching the RAM latency and a skid buffer feeding a
// valid/ready stream. Define FIFO_RD_STREAM_STATS_EN to add stall_cnt.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_rd,
  input  logic                  rst_n_rd,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  localparam int unsigned DEPTH     = RD_LATENCY + 1;
  localparam int unsigned OCC_WIDTH = clog2_min1(DEPTH + 1);
  localparam int unsigned SW        = OCC_WIDTH + 1;

  if (!`FIFO_RD_LATENCY_LEGAL(RD_LATENCY) || (CNT_WIDTH == 0)) begin : g_bad_cfg
    $error("fifo_rd_stream: RD_LATENCY must be 1..2 and CNT_WIDTH non-zero");
  end

  logic [RD_LATENCY-1:0] inflight;
  logic [RD_LATENCY-1:0] inflight_nxt;
  logic [SW-1:0]         nif;
  logic [OCC_WIDTH-1:0]  occ;
  logic                  pop;
  logic                  push;
  logic                  credit_ok;

  assign inflight_nxt = (inflight << 1) | RD_LATENCY'(fifo_rd_en);

  gnrl_dffr #(.DW(RD_LATENCY)) u_inflight (
    .clk   (clk_rd),
    .rst_n (rst_n_rd),
    .dnxt  (inflight_nxt),
    .qout  (inflight)
  );

  always_comb begin
    nif = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) nif = nif + SW'(inflight[i]);
  end

  // occ + nif - pop < DEPTH, rearranged so the subtraction cannot wrap.
  assign pop        = m_valid && m_ready;
  assign push       = inflight[RD_LATENCY-1];
  assign credit_ok  = (SW'(occ) + nif) < (SW'(DEPTH) + SW'(pop));
  assign fifo_rd_en = rst_n_rd && !fifo_empty && credit_ok;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .OCC_WIDTH  (OCC_WIDTH)
  ) u_skid (
    .clk       (clk_rd),
    .rst_n     (rst_n_rd),
    .push      (push),
    .push_data (fifo_rd_dout),
    .pop       (pop),
    .valid     (m_valid),
    .head_data (m_data),
    .occ       (occ)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk_rd or negedge rst_n_rd) begin
    if (!rst_n_rd)
      stall_cnt <= '0;
    else if (m_valid && !m_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: two instances (RD_LATENCY 1 and 2)
// fed from FIFO models, outputs compared against the written word order.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty   [2];
  logic          fifo_rd_en   [2];
  logic [DW-1:0] fifo_rd_dout [2];
  logic          m_valid      [2];
  logic          m_ready      [2];
  logic [DW-1:0] m_data       [2];
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [2:0]    stall_a;
  logic [15:0]   stall_b;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(1), .CNT_WIDTH(3)) u_dut_l1 (
    .clk_rd       (clk),
    .rst_n_rd     (rst_n),
    .fifo_empty   (fifo_empty[0]),
    .fifo_rd_en   (fifo_rd_en[0]),
    .fifo_rd_dout (fifo_rd_dout[0]),
    .m_valid      (m_valid[0]),
    .m_ready      (m_ready[0]),
    .m_data       (m_data[0])
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stall_cnt    (stall_a)
`endif
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(2), .CNT_WIDTH(16)) u_dut_l2 (
    .clk_rd       (clk),
    .rst_n_rd     (rst_n),
    .fifo_empty   (fifo_empty[1]),
    .fifo_rd_en   (fifo_rd_en[1]),
    .fifo_rd_dout (fifo_rd_dout[1]),
    .m_valid      (m_valid[1]),
    .m_ready      (m_ready[1]),
    .m_data       (m_data[1])
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stall_cnt    (stall_b)
`endif
  );

  logic [DW-1:0] fifo_q [2][$];
  logic [DW-1:0] exp_q  [2][$];
  logic [DW-1:0] pipe   [2][2];
  logic [DW-1:0] rd_word [2];
  bit            rd_vld  [2];
  bit            prev_hold [2];
  logic [DW-1:0] prev_data [2];
  int            outstanding [2];
  int            beats [2];
  int            first_rd [2];
  int            first_vld [2];
  int            first_beat [2];
  int            last_beat [2];
  int            stall_m [2];
  int            cyc = 0;
  int unsigned   ready_mode = 0;
  bit            pess_en = 0;
  bit            toggle_ph = 0;
  int            tests = 0;
  int            fails = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int depth_of(input int k);
    return lat_of(k) + 1;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

`ifdef FIFO_RD_STREAM_STATS_EN
  function automatic int stall_act(input int k);
    return (k == 0) ? int'(stall_a) : int'(stall_b);
  endfunction
  function automatic int stall_max(input int k);
    return (k == 0) ? 7 : 65535;
  endfunction
`endif

  // FIFO model, ready generator and output monitor.
  initial begin : monitor
    logic [DW-1:0] e;
    for (int k = 0; k < 2; k++) begin
      fifo_empty[k]   = 1'b1;
      m_ready[k]      = 1'b1;
      fifo_rd_dout[k] = '0;
      pipe[k][0] = '0;
      pipe[k][1] = '0;
      rd_vld[k] = 0;
      prev_hold[k] = 0;
      outstanding[k] = 0;
      stall_m[k] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
`ifdef FIFO_RD_STREAM_STATS_EN
        check(stall_act(k) == stall_m[k], "stall_cnt", stall_act(k), stall_m[k]);
`endif
        if (!rst_n) begin
          check(fifo_rd_en[k] == 1'b0, "rd_en_in_reset", fifo_rd_en[k], 0);
          check(m_valid[k] == 1'b0, "valid_in_reset", m_valid[k], 0);
          prev_hold[k] = 0;
        end else begin
          if (prev_hold[k]) begin
            check(m_valid[k] == 1'b1, "hold_valid", m_valid[k], 1);
            check(m_data[k] == prev_data[k], "hold_data", m_data[k], prev_data[k]);
          end
          if (fifo_rd_en[k]) begin
            if (first_rd[k] < 0) first_rd[k] = cyc;
            if (fifo_q[k].size() == 0) check(0, "over_read", 1, 0);
            else begin
              rd_word[k] = fifo_q[k].pop_front();
              rd_vld[k]  = 1;
              outstanding[k]++;
            end
          end
          if (m_valid[k] && first_vld[k] < 0) first_vld[k] = cyc;
          if (m_valid[k] && m_ready[k]) begin
            if (exp_q[k].size() == 0) check(0, "unexpected_beat", m_data[k], -1);
            else begin
              e = exp_q[k].pop_front();
              check(m_data[k] == e, "beat_data", m_data[k], e);
            end
            outstanding[k]--;
            beats[k]++;
            if (first_beat[k] < 0) first_beat[k] = cyc;
            last_beat[k] = cyc;
          end
          check(outstanding[k] <= depth_of(k), "outstanding", outstanding[k], depth_of(k));
`ifdef FIFO_RD_STREAM_STATS_EN
          if (m_valid[k] && !m_ready[k] && stall_m[k] < stall_max(k)) stall_m[k]++;
`endif
          prev_hold[k] = m_valid[k] && !m_ready[k];
          prev_data[k] = m_data[k];
        end
      end
      @(posedge clk);
      #1;
      toggle_ph = !toggle_ph;
      for (int k = 0; k < 2; k++) begin
        pipe[k][1] = pipe[k][0];
        pipe[k][0] = rd_vld[k] ? rd_word[k] : DW'($urandom);
        rd_vld[k]  = 0;
        fifo_rd_dout[k] = (lat_of(k) == 1) ? pipe[k][0] : pipe[k][1];
        fifo_empty[k] = (fifo_q[k].size() == 0) || (pess_en && $urandom_range(0, 3) == 0);
        case (ready_mode)
          0:       m_ready[k] = 1'b1;
          1:       m_ready[k] = 1'b0;
          2:       m_ready[k] = toggle_ph;
          default: m_ready[k] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    for (int k = 0; k < 2; k++) begin
      fifo_q[k].push_back(w);
      exp_q[k].push_back(w);
    end
  endtask

  task automatic clear_trackers();
    for (int k = 0; k < 2; k++) begin
      beats[k] = 0;
      first_rd[k] = -1;
      first_vld[k] = -1;
      first_beat[k] = -1;
      last_beat[k] = -1;
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && c < budget) begin
      step(1);
      c++;
    end
    for (int k = 0; k < 2; k++)
      check(exp_q[k].size() == 0, "drain_left", exp_q[k].size(), 0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c;
    clear_trackers();
    rst_n = 1'b0;
    step(20);
    for (int k = 0; k < 2; k++) check(m_data[k] == '0, "reset_data", m_data[k], 0);
    rst_n = 1'b1;
    step(2);

    // Continuous stream: latency and gap-free throughput.
    clear_trackers();
    ready_mode = 0;
    for (int i = 0; i < 16; i++) write_word(DW'(i));
    drain(100);
    for (int k = 0; k < 2; k++) begin
      check(first_vld[k] - first_rd[k] == lat_of(k) + 1, "first_latency",
            first_vld[k] - first_rd[k], lat_of(k) + 1);
      check(beats[k] == 16, "stream_beats", beats[k], 16);
      check(last_beat[k] - first_beat[k] == 15, "stream_gaps",
            last_beat[k] - first_beat[k], 15);
    end
    step(3);

    // Backpressure: reads stop at DEPTH, head word held.
    ready_mode = 1;
    for (int i = 0; i < 8; i++) write_word(DW'(8'h20 + i));
    step(14);
    for (int k = 0; k < 2; k++) begin
      check(fifo_rd_en[k] == 1'b0, "bp_rd_en", fifo_rd_en[k], 0);
      check(m_valid[k] == 1'b1, "bp_valid", m_valid[k], 1);
      check(m_data[k] == 8'h20, "bp_head", m_data[k], 32'h20);
      check(outstanding[k] == depth_of(k), "bp_reads", outstanding[k], depth_of(k));
    end
`ifdef FIFO_RD_STREAM_STATS_EN
    check(stall_a == 3'd7, "stall_saturated", stall_a, 7);
`endif
    ready_mode = 0;
    drain(100);

    // Alternating ready.
    ready_mode = 2;
    for (int i = 0; i < 32; i++) write_word(DW'($urandom));
    drain(300);

    // Reset in the middle of a burst.
    clear_trackers();
    ready_mode = 0;
    for (int i = 0; i < 10; i++) write_word(DW'(8'h40 + i));
    c = 0;
    while ((beats[0] < 5 || beats[1] < 5) && c < 100) begin
      step(1);
      c++;
    end
    check(beats[0] >= 5 && beats[1] >= 5, "mid_burst_reach", beats[1], 5);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q[k] = fifo_q[k];
      outstanding[k] = 0;
      stall_m[k] = 0;
    end
    #1;
    for (int k = 0; k < 2; k++) check(m_valid[k] == 1'b0, "async_reset_valid", m_valid[k], 0);
    step(3);
    rst_n = 1'b1;
    drain(100);

    // Randomized traffic with pessimistic empty.
    ready_mode = 3;
    pess_en = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 4)) write_word(DW'($urandom));
      step(1);
    end
    drain(500);
    pess_en = 0;
    ready_mode = 0;
    step(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
